// File: rtl/omicron_wb_pkg.sv
// rtl/omicron_wb_pkg.sv - shared encodings for the omicron write-back stage
package omicron_wb_pkg;

  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_MEM  = 2'b01;
  localparam logic [1:0] SEL_LINK = 2'b10;

  localparam logic [1:0] LD_WORD = 2'b00;
  localparam logic [1:0] LD_LBU  = 2'b01;
  localparam logic [1:0] LD_LBS  = 2'b10;
  localparam logic [1:0] LD_HBU  = 2'b11;

endpackage

// File: rtl/wb_load_align.sv
// rtl/wb_load_align.sv - sub-word load extraction with sign/zero extension
module wb_load_align
  import omicron_wb_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] dout,
  input  logic [1:0]        mode,
  output logic [DATA_W-1:0] aligned
);

  always_comb begin
    aligned = dout;
    case (mode)
      LD_WORD: aligned = dout;
      LD_LBU:  aligned = {{(DATA_W-8){1'b0}}, dout[7:0]};
      LD_LBS:  aligned = {{(DATA_W-8){dout[7]}}, dout[7:0]};
      LD_HBU:  aligned = {{(DATA_W-8){1'b0}}, dout[15:8]};
      default: aligned = dout;
    endcase
  end

endmodule

// File: rtl/write_back_pipe.sv
// rtl/write_back_pipe.sv - registered MEM/WB boundary with result select,
// load alignment, stall/flush control and a retired-instruction counter
module write_back_pipe
  import omicron_wb_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 3,
  parameter int ZERO_REG_EN = 1,
  parameter int RETIRE_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m_valid,
  input  logic [DATA_W-1:0]   m_alu_result,
  input  logic [DATA_W-1:0]   m_dm_dout,
  input  logic [DATA_W-1:0]   m_link_addr,
  input  logic [ADDR_W-1:0]   m_reg_waddr,
  input  logic [1:0]          cu_reg_data_sel,
  input  logic [1:0]          cu_load_mode,
  input  logic                cu_reg_load,
  input  logic                wb_stall,
  input  logic                wb_flush,
  output logic [DATA_W-1:0]   wb_reg_wdata,
  output logic                wb_reg_wea,
  output logic [ADDR_W-1:0]   wb_reg_waddr,
  output logic                wb_valid,
  output logic [RETIRE_W-1:0] wb_retired
);

  logic [DATA_W-1:0]   mem_aligned;
  logic [DATA_W-1:0]   next_wdata;

  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic                valid_q, valid_d;
  logic                load_q, load_d;
  logic [RETIRE_W-1:0] retired_q, retired_d;
  logic                zero_dest;

  wb_load_align #(
    .DATA_W (DATA_W)
  ) u_align (
    .dout    (m_dm_dout),
    .mode    (cu_load_mode),
    .aligned (mem_aligned)
  );

  // Reserved select 11 falls back to the ALU result.
  always_comb begin
    next_wdata = m_alu_result;
    case (cu_reg_data_sel)
      SEL_MEM:  next_wdata = mem_aligned;
      SEL_LINK: next_wdata = m_link_addr;
      default:  next_wdata = m_alu_result;
    endcase
  end

  // Flush only kills valid/load; data and address are left as they were.
  always_comb begin
    wdata_d = wdata_q;
    waddr_d = waddr_q;
    valid_d = valid_q;
    load_d  = load_q;
    if (wb_flush) begin
      valid_d = 1'b0;
      load_d  = 1'b0;
    end else if (!wb_stall) begin
      valid_d = m_valid;
      load_d  = m_valid & cu_reg_load;
      wdata_d = next_wdata;
      waddr_d = m_reg_waddr;
    end
  end

  // The entry in WB retires when it leaves; a flush does not cancel that.
  always_comb begin
    retired_d = retired_q;
    if (valid_q && !wb_stall) begin
      retired_d = retired_q + RETIRE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wdata_q   <= '0;
      waddr_q   <= '0;
      valid_q   <= 1'b0;
      load_q    <= 1'b0;
      retired_q <= '0;
    end else begin
      wdata_q   <= wdata_d;
      waddr_q   <= waddr_d;
      valid_q   <= valid_d;
      load_q    <= load_d;
      retired_q <= retired_d;
    end
  end

  assign zero_dest    = (ZERO_REG_EN != 0) && (waddr_q == '0);
  assign wb_reg_wea   = valid_q & load_q & ~zero_dest;
  assign wb_reg_wdata = wdata_q;
  assign wb_reg_waddr = waddr_q;
  assign wb_valid     = valid_q;
  assign wb_retired   = retired_q;

endmodule

// File: tb/tb_write_back_pipe.sv
// tb/tb_write_back_pipe.sv - directed self-checking bench for write_back_pipe
module tb_write_back_pipe;
  import omicron_wb_pkg::*;

  logic        clk;
  logic        rst;
  logic        m_valid;
  logic [15:0] m_alu_result;
  logic [15:0] m_dm_dout;
  logic [15:0] m_link_addr;
  logic [2:0]  m_reg_waddr;
  logic [1:0]  cu_reg_data_sel;
  logic [1:0]  cu_load_mode;
  logic        cu_reg_load;
  logic        wb_stall;
  logic        wb_flush;

  logic [15:0] wb_reg_wdata;
  logic        wb_reg_wea;
  logic [2:0]  wb_reg_waddr;
  logic        wb_valid;
  logic [15:0] wb_retired;

  logic [15:0] w4_reg_wdata;
  logic        w4_reg_wea;
  logic [2:0]  w4_reg_waddr;
  logic        w4_valid;
  logic [3:0]  w4_retired;

  int n_checks = 0;
  int n_fails  = 0;

  write_back_pipe dut (
    .clk             (clk),
    .rst             (rst),
    .m_valid         (m_valid),
    .m_alu_result    (m_alu_result),
    .m_dm_dout       (m_dm_dout),
    .m_link_addr     (m_link_addr),
    .m_reg_waddr     (m_reg_waddr),
    .cu_reg_data_sel (cu_reg_data_sel),
    .cu_load_mode    (cu_load_mode),
    .cu_reg_load     (cu_reg_load),
    .wb_stall        (wb_stall),
    .wb_flush        (wb_flush),
    .wb_reg_wdata    (wb_reg_wdata),
    .wb_reg_wea      (wb_reg_wea),
    .wb_reg_waddr    (wb_reg_waddr),
    .wb_valid        (wb_valid),
    .wb_retired      (wb_retired)
  );

  write_back_pipe #(
    .RETIRE_W (4)
  ) dut_w4 (
    .clk             (clk),
    .rst             (rst),
    .m_valid         (m_valid),
    .m_alu_result    (m_alu_result),
    .m_dm_dout       (m_dm_dout),
    .m_link_addr     (m_link_addr),
    .m_reg_waddr     (m_reg_waddr),
    .cu_reg_data_sel (cu_reg_data_sel),
    .cu_load_mode    (cu_load_mode),
    .cu_reg_load     (cu_reg_load),
    .wb_stall        (wb_stall),
    .wb_flush        (wb_flush),
    .wb_reg_wdata    (w4_reg_wdata),
    .wb_reg_wea      (w4_reg_wea),
    .wb_reg_waddr    (w4_reg_waddr),
    .wb_valid        (w4_valid),
    .wb_retired      (w4_retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_alu(input logic v, input logic [15:0] alu, input logic [2:0] wa, input logic ld);
    m_valid         = v;
    m_alu_result    = alu;
    m_reg_waddr     = wa;
    cu_reg_load     = ld;
    cu_reg_data_sel = SEL_ALU;
    cu_load_mode    = LD_WORD;
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    wb_stall = 1'b0;
    wb_flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_valid         = 1'b1;
      m_alu_result    = 16'($urandom);
      m_dm_dout       = 16'($urandom);
      m_link_addr     = 16'($urandom);
      m_reg_waddr     = 3'($urandom);
      cu_reg_data_sel = 2'($urandom);
      cu_load_mode    = 2'($urandom);
      cu_reg_load     = 1'b1;
      cyc();
    end
    n_checks++;
    if ({wb_reg_wdata, wb_reg_wea, wb_reg_waddr, wb_valid, wb_retired} !== 36'h0) begin
      n_fails++;
      $display("FAIL reset_outputs: got wdata=%h wea=%b waddr=%0d valid=%b retired=%0d, want all 0",
               wb_reg_wdata, wb_reg_wea, wb_reg_waddr, wb_valid, wb_retired);
    end
    n_checks++;
    if (w4_retired !== 4'd0 || w4_valid !== 1'b0) begin
      n_fails++;
      $display("FAIL reset_w4: got retired=%0d valid=%b, want 0 0", w4_retired, w4_valid);
    end
    rst = 1'b0;
    set_alu(1'b1, 16'h1234, 3'd3, 1'b1);
    cyc();
    n_checks++;
    if (wb_reg_wdata !== 16'h1234 || wb_reg_waddr !== 3'd3 || wb_reg_wea !== 1'b1 || wb_valid !== 1'b1) begin
      n_fails++;
      $display("FAIL first_capture: got wdata=%h waddr=%0d wea=%b valid=%b, want 1234 3 1 1",
               wb_reg_wdata, wb_reg_waddr, wb_reg_wea, wb_valid);
    end
    n_checks++;
    if (wb_retired !== 16'd0) begin
      n_fails++;
      $display("FAIL first_retire_early: got %0d, want 0", wb_retired);
    end
    set_alu(1'b0, 16'h0000, 3'd0, 1'b0);
    cyc();
    n_checks++;
    if (wb_retired !== 16'd1 || wb_valid !== 1'b0 || wb_reg_wea !== 1'b0) begin
      n_fails++;
      $display("FAIL first_retire: got retired=%0d valid=%b wea=%b, want 1 0 0", wb_retired, wb_valid, wb_reg_wea);
    end
  endtask

  task automatic test_load_align();
    logic [15:0] douts [5];
    logic [1:0]  modes [5];
    logic [15:0] exps  [5];
    douts = '{16'hA5F0, 16'hA5F0, 16'hA5F0, 16'hA5F0, 16'h0070};
    modes = '{LD_WORD, LD_LBU, LD_LBS, LD_HBU, LD_LBS};
    exps  = '{16'hA5F0, 16'h00F0, 16'hFFF0, 16'h00A5, 16'h0070};
    for (int i = 0; i < 5; i++) begin
      set_alu(1'b1, 16'hDEAD, 3'd1, 1'b1);
      cu_reg_data_sel = SEL_MEM;
      cu_load_mode    = modes[i];
      m_dm_dout       = douts[i];
      cyc();
      n_checks++;
      if (wb_reg_wdata !== exps[i] || wb_reg_wea !== 1'b1) begin
        n_fails++;
        $display("FAIL load_align[%0d] mode=%0d: got wdata=%h wea=%b, want %h 1",
                 i, modes[i], wb_reg_wdata, wb_reg_wea, exps[i]);
      end
    end
    // Load mode must be ignored for the ALU source.
    set_alu(1'b1, 16'hBEEF, 3'd1, 1'b1);
    cu_load_mode = LD_HBU;
    cyc();
    n_checks++;
    if (wb_reg_wdata !== 16'hBEEF) begin
      n_fails++;
      $display("FAIL alu_ignores_mode: got %h, want beef", wb_reg_wdata);
    end
    set_alu(1'b1, 16'hCAFE, 3'd2, 1'b1);
    cu_reg_data_sel = 2'b11;
    cyc();
    n_checks++;
    if (wb_reg_wdata !== 16'hCAFE) begin
      n_fails++;
      $display("FAIL sel_reserved: got %h, want cafe", wb_reg_wdata);
    end
  endtask

  task automatic test_link_zero_reg();
    logic [15:0] r;
    set_alu(1'b1, 16'h1111, 3'd7, 1'b1);
    cu_reg_data_sel = SEL_LINK;
    m_link_addr     = 16'h0042;
    cyc();
    n_checks++;
    if (wb_reg_wdata !== 16'h0042 || wb_reg_wea !== 1'b1 || wb_reg_waddr !== 3'd7) begin
      n_fails++;
      $display("FAIL link: got wdata=%h wea=%b waddr=%0d, want 0042 1 7", wb_reg_wdata, wb_reg_wea, wb_reg_waddr);
    end
    set_alu(1'b1, 16'h5555, 3'd0, 1'b1);
    cyc();
    r = wb_retired;
    n_checks++;
    if (wb_reg_wea !== 1'b0 || wb_valid !== 1'b1) begin
      n_fails++;
      $display("FAIL zero_reg: got wea=%b valid=%b, want 0 1", wb_reg_wea, wb_valid);
    end
    set_alu(1'b0, 16'h0, 3'd0, 1'b0);
    cyc();
    n_checks++;
    if (wb_retired !== r + 16'd1) begin
      n_fails++;
      $display("FAIL zero_reg_retire: got %0d, want %0d", wb_retired, r + 16'd1);
    end
  endtask

  task automatic test_stall_flush();
    logic [15:0] r;
    set_alu(1'b1, 16'h0011, 3'd2, 1'b1);
    cyc();
    r = wb_retired;
    wb_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_alu(1'b1, 16'h9990 + 16'(i), 3'd5, 1'b0);
      cyc();
      n_checks++;
      if (wb_reg_wdata !== 16'h0011 || wb_reg_waddr !== 3'd2 || wb_reg_wea !== 1'b1 ||
          wb_valid !== 1'b1 || wb_retired !== r) begin
        n_fails++;
        $display("FAIL stall_hold[%0d]: got wdata=%h waddr=%0d wea=%b valid=%b retired=%0d, want 0011 2 1 1 %0d",
                 i, wb_reg_wdata, wb_reg_waddr, wb_reg_wea, wb_valid, wb_retired, r);
      end
    end
    wb_stall = 1'b0;
    set_alu(1'b0, 16'h0, 3'd0, 1'b0);
    cyc();
    n_checks++;
    if (wb_retired !== r + 16'd1 || wb_valid !== 1'b0) begin
      n_fails++;
      $display("FAIL stall_release: got retired=%0d valid=%b, want %0d 0", wb_retired, wb_valid, r + 16'd1);
    end
    set_alu(1'b1, 16'h0022, 3'd4, 1'b1);
    cyc();
    r = wb_retired;
    wb_stall = 1'b1;
    wb_flush = 1'b1;
    cyc();
    n_checks++;
    if (wb_valid !== 1'b0 || wb_reg_wea !== 1'b0 || wb_retired !== r) begin
      n_fails++;
      $display("FAIL stall_flush: got valid=%b wea=%b retired=%0d, want 0 0 %0d", wb_valid, wb_reg_wea, wb_retired, r);
    end
    wb_stall = 1'b0;
    wb_flush = 1'b0;
    set_alu(1'b1, 16'h0033, 3'd4, 1'b1);
    cyc();
    r = wb_retired;
    wb_flush = 1'b1;
    cyc();
    n_checks++;
    if (wb_valid !== 1'b0 || wb_reg_wea !== 1'b0 || wb_retired !== r + 16'd1 || wb_reg_wdata !== 16'h0033) begin
      n_fails++;
      $display("FAIL flush_retires: got valid=%b wea=%b retired=%0d wdata=%h, want 0 0 %0d 0033",
               wb_valid, wb_reg_wea, wb_retired, wb_reg_wdata, r + 16'd1);
    end
    wb_flush = 1'b0;
  endtask

  task automatic test_counter_wrap();
    rst = 1'b1;
    set_alu(1'b0, 16'h0, 3'd0, 1'b0);
    cyc();
    rst = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      set_alu(1'b1, 16'(k), 3'd1, 1'b1);
      cyc();
      n_checks++;
      if (w4_retired !== 4'((k - 1) % 16)) begin
        n_fails++;
        $display("FAIL wrap[%0d]: got %0d, want %0d", k, w4_retired, (k - 1) % 16);
      end
    end
    set_alu(1'b0, 16'h0, 3'd0, 1'b0);
    cyc();
    n_checks++;
    if (w4_retired !== 4'd1 || wb_retired !== 16'd17) begin
      n_fails++;
      $display("FAIL wrap_final: got w4=%0d w16=%0d, want 1 17", w4_retired, wb_retired);
    end
  endtask

  task automatic test_bubble_reset();
    logic [9:0] train;
    train = 10'b1011001011;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      set_alu(train[i], 16'h0100 + 16'(i), 3'd6, 1'b1);
      cyc();
      if (!train[i]) begin
        n_checks++;
        if (wb_valid !== 1'b0 || wb_reg_wea !== 1'b0) begin
          n_fails++;
          $display("FAIL bubble[%0d]: got valid=%b wea=%b, want 0 0", i, wb_valid, wb_reg_wea);
        end
      end
    end
    set_alu(1'b0, 16'h0, 3'd0, 1'b0);
    cyc();
    n_checks++;
    if (wb_retired !== 16'd6) begin
      n_fails++;
      $display("FAIL train_count: got %0d, want 6", wb_retired);
    end
    set_alu(1'b1, 16'h0777, 3'd3, 1'b1);
    cyc();
    wb_stall = 1'b1;
    rst      = 1'b1;
    cyc();
    n_checks++;
    if ({wb_reg_wdata, wb_reg_wea, wb_reg_waddr, wb_valid, wb_retired} !== 36'h0) begin
      n_fails++;
      $display("FAIL reset_in_stall: got wdata=%h wea=%b waddr=%0d valid=%b retired=%0d, want all 0",
               wb_reg_wdata, wb_reg_wea, wb_reg_waddr, wb_valid, wb_retired);
    end
    rst      = 1'b0;
    wb_stall = 1'b0;
    set_alu(1'b1, 16'h0888, 3'd5, 1'b1);
    cyc();
    set_alu(1'b0, 16'h0, 3'd0, 1'b0);
    cyc();
    n_checks++;
    if (wb_retired !== 16'd1) begin
      n_fails++;
      $display("FAIL resume_after_reset: got %0d, want 1", wb_retired);
    end
  endtask

  initial begin
    test_reset();
    test_load_align();
    test_link_zero_reg();
    test_stall_flush();
    test_counter_wrap();
    test_bubble_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/write_back_pipe.md
Name: write_back_pipe

Overview:
Parametrised write-back stage for the omicron pipeline. It replaces the purely combinational ALU/memory mux with a registered MEM/WB boundary.
- Adds a third result source (link address), sub-word load alignment with sign/zero extension, and stall/flush control.
- Optionally suppresses writes to register 0.
- Counts retired instructions.
- Sits between the memory stage and the register file / ID-stage forwarding logic.

Parameters:
DATA_W, 16, datapath width; must be >= 16.
ADDR_W, 3, register-file address width.
ZERO_REG_EN, 1, when 1, writes to register 0 are suppressed.
RETIRE_W, 16, width of the retired-instruction counter.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
m_valid  input  1  memory stage holds a valid instruction
m_alu_result  input  DATA_W  ALU result from memory stage
m_dm_dout  input  DATA_W  data-memory read word
m_link_addr  input  DATA_W  return address (PC+1) for call/link ops
m_reg_waddr  input  ADDR_W  destination register
cu_reg_data_sel  input  2  00 ALU, 01 memory, 10 link, 11 reserved (treated as 00)
cu_load_mode  input  2  00 word, 01 low byte zero-ext, 10 low byte sign-ext, 11 high byte zero-ext
cu_reg_load  input  1  instruction writes a register
wb_stall  input  1  hold WB register contents
wb_flush  input  1  invalidate the entry being captured
wb_reg_wdata  output  DATA_W  register-file write data
wb_reg_wea  output  1  register-file write enable
wb_reg_waddr  output  ADDR_W  register-file write address
wb_valid  output  1  WB register holds a valid instruction
wb_retired  output  RETIRE_W  retired-instruction count

Behaviour:
- One clock; reset is synchronous and active-high. All state updates on the rising edge of clk.
- Reset values:
  - wb_valid=0, wb_reg_wdata=0, wb_reg_waddr=0, wb_reg_wea=0, wb_retired=0.
  - Internal load flag resets to 0.
- Next-data selection (combinational, from m_* inputs):
  - sel 00/11: m_alu_result.
  - sel 10: m_link_addr.
  - sel 01: m_dm_dout aligned per cu_load_mode:
    - mode 00: full word.
    - mode 01: {0, dout[7:0]}.
    - mode 10: {replicate dout[7], dout[7:0]}.
    - mode 11: {0, dout[15:8]}.
  - cu_load_mode is ignored unless sel=01.
- Update priority each edge: rst > wb_flush > wb_stall > capture.
  - rst: all registers cleared.
  - wb_flush: wb_valid<=0 and load flag<=0. Data and address are don't-care but are held. Flush wins over a simultaneous stall.
  - wb_stall (no flush): all WB registers hold their values.
  - capture: wb_valid<=m_valid; load flag<=m_valid & cu_reg_load; wb_reg_wdata<=selected data; wb_reg_waddr<=m_reg_waddr.
- Latency: exactly 1 cycle from m_* inputs to wb_* outputs.
- wb_reg_wea (combinational from registered state) = wb_valid & load flag & !(ZERO_REG_EN & wb_reg_waddr==0).
  - wea stays asserted while stalled. The repeated write is idempotent by design.
- Retire counter:
  - Increments by 1 on each edge where wb_valid=1, wb_stall=0, rst=0. Flush does not block retirement of the current entry.
  - Wraps from 2^RETIRE_W-1 to 0 with no sticky flag.
- Bubbles: m_valid=0 captures as wb_valid=0 and wea=0, with no retirement on the following cycle.
- Reset asserted mid-stall or mid-flush clears everything on that edge; operation resumes with the first capture after rst deasserts.

Decomposition:
- Package omicron_wb_pkg:
  - Localparams SEL_ALU=2'b00, SEL_MEM=2'b01, SEL_LINK=2'b10.
  - Localparams LD_WORD=2'b00, LD_LBU=2'b01, LD_LBS=2'b10, LD_HBU=2'b11.
- One sub-module, wb_load_align, is natural: a combinational DATA_W-generic byte extractor/extender (inputs dout, mode; output aligned word).
- The pipeline register, wea logic and counter stay in the top module.

Test Plan:
1. Reset: hold rst=1 for 2 cycles with random m_* inputs -> all outputs 0. Release, then apply m_valid=1, sel=00, alu=16'h1234, waddr=3, load=1 -> next cycle wdata=16'h1234, waddr=3, wea=1, wb_valid=1; wb_retired=1 one cycle later.
2. Load alignment with sel=01, dout=16'hA5F0:
   - mode 00 -> 16'hA5F0.
   - mode 01 -> 16'h00F0.
   - mode 10 -> 16'hFFF0.
   - mode 11 -> 16'h00A5.
   - Also dout=16'h0070 with mode 10 -> 16'h0070.
3. Link and zero register:
   - sel=10, link=16'h0042, waddr=7 -> wdata=16'h0042, wea=1.
   - waddr=0, load=1 with ZERO_REG_EN=1 -> wea=0 but wb_valid=1, and the counter still increments.
4. Stall/flush:
   - Capture A (wdata=16'h0011), then stall 3 cycles while inputs change -> outputs stay A, wea=1 throughout, counter unchanged until the stall drops, then +1.
   - Stall and flush together -> wb_valid=0 and wea=0 next cycle.
5. Counter wrap: with RETIRE_W=4, retire 17 back-to-back valid instructions -> wb_retired goes 15->0->1.
6. Bubble and reset mid-operation: a train of valid/invalid entries -> counter equals the number of valid entries. Asserting rst during a stall -> outputs and counter cleared on that edge.
